fifo_flags: RTL and testbench

Parametrised synchronous FIFO with status flags and error detection. It is the next generation of the team's single-clock buffer.
- Adds full/empty, programmable almost-full/almost-empty, an occupancy count, sticky overflow/underflow, synchronous flush, and a selectable show-ahead or registered read port.
- Sits between a producer and a consumer in one clock domain; intended for power-aware simulation test designs.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_ram.sv | 43 ++++
 rtl/fifo_flags.sv | 109 ++++++++++
 tb/tb_fifo_flags.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and elaboration-time helpers for the fifo_flags block.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 256;

  // Smallest n with 2**n >= v; usable in constant expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Legal configurations: DEPTH a power of two and at least 4,
  // and the almost-empty threshold strictly below almost-full.
  function automatic bit params_ok(input int width, input int depth,
                                   input int af, input int ae);
    return (width >= 1) && (depth >= 4) && ((depth & (depth - 1)) == 0) &&
           (ae < af) && (af <= depth);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port WIDTH x DEPTH storage; read port is either a
// combinational look at the head entry or a register loaded on read.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AW        = clog2(DEPTH),
  parameter bit SHOWAHEAD = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is not reset; only written entries are ever observed.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  if (SHOWAHEAD) begin : g_showahead
    logic unused_rd;
    assign unused_rd = re ^ reset_n;
    assign rdata = mem[raddr];
  end else begin : g_registered
    logic [WIDTH-1:0] rdata_q;
    // Capture the popped word; the read sees the pre-edge contents even
    // when a write to the same address happens on this edge.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  rdata_q <= '0;
      else if (re)   rdata_q <= mem[raddr];
    end
    assign rdata = rdata_q;
  end

endmodule

// File: rtl/fifo_flags.sv
// Single-clock FIFO with registered status flags, occupancy count,
// sticky overflow/underflow and synchronous flush.
module fifo_flags
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_LEVEL  = DEPTH - 4,
  parameter int AE_LEVEL  = 4,
  parameter bit SHOWAHEAD = 1'b1,
  localparam int AW       = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             err_clr,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             almost_full,
  output logic             empty,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  if (!params_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("fifo_flags: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

  logic [AW-1:0] waddr_q, raddr_q;
  logic [AW:0]   cnt_q, cnt_nxt;
  logic          full_q, afull_q, empty_q, aempty_q, ovf_q, unf_q;
  logic          pop_ok, push_ok, wr_en, rd_en, ovf_ev, unf_ev;

  // Acceptance uses only registered flags, so no push/pop -> flag path.
  assign pop_ok  = pop && !empty_q;
  assign push_ok = push && (!full_q || pop_ok);
  assign wr_en   = push_ok && !flush;
  assign rd_en   = pop_ok && !flush;
  assign ovf_ev  = push && !push_ok && !flush;
  assign unf_ev  = pop && empty_q && !flush;
  assign cnt_nxt = flush ? '0 : cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);

  // Pointers, count and flags; flags derive from the next count so they
  // line up with count in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      waddr_q  <= '0;
      raddr_q  <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
    end else begin
      waddr_q  <= flush ? '0 : waddr_q + AW'(wr_en);
      raddr_q  <= flush ? '0 : raddr_q + AW'(rd_en);
      cnt_q    <= cnt_nxt;
      full_q   <= (cnt_nxt == DEPTH_C);
      afull_q  <= (cnt_nxt >= AF_C);
      empty_q  <= (cnt_nxt == '0);
      aempty_q <= (cnt_nxt <= AE_C);
    end
  end

  // Sticky errors: a same-cycle event overrides err_clr; flush keeps them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_ev | (ovf_q & ~err_clr);
      unf_q <= unf_ev | (unf_q & ~err_clr);
    end
  end

  fifo_ram #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AW        (AW),
    .SHOWAHEAD (SHOWAHEAD)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wr_en),
    .waddr   (waddr_q),
    .wdata   (din),
    .re      (rd_en),
    .raddr   (raddr_q),
    .rdata   (dout)
  );

  assign full         = full_q;
  assign almost_full  = afull_q;
  assign empty        = empty_q;
  assign almost_empty = aempty_q;
  assign count        = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_flags.sv
// Bench for fifo_flags: a show-ahead and a registered-read instance share
// one stimulus stream and are compared each cycle against a queue model.
module tb_fifo_flags;

  localparam int W = 8;
  localparam int D = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0, push = 1'b0, pop = 1'b0, err_clr = 1'b0;
  logic [W-1:0] din = '0;

  logic [W-1:0] sa_dout, rg_dout;
  logic sa_full, sa_afull, sa_empty, sa_aempty, sa_ovf, sa_unf;
  logic rg_full, rg_afull, rg_empty, rg_aempty, rg_ovf, rg_unf;
  logic [3:0] sa_count, rg_count;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_flags #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .SHOWAHEAD(1'b1)) u_sa (
    .clk(clk), .reset_n(reset_n), .flush(flush), .push(push), .din(din), .pop(pop),
    .err_clr(err_clr), .dout(sa_dout), .full(sa_full), .almost_full(sa_afull),
    .empty(sa_empty), .almost_empty(sa_aempty), .count(sa_count),
    .overflow(sa_ovf), .underflow(sa_unf));

  fifo_flags #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .SHOWAHEAD(1'b0)) u_rg (
    .clk(clk), .reset_n(reset_n), .flush(flush), .push(push), .din(din), .pop(pop),
    .err_clr(err_clr), .dout(rg_dout), .full(rg_full), .almost_full(rg_afull),
    .empty(rg_empty), .almost_empty(rg_aempty), .count(rg_count),
    .overflow(rg_ovf), .underflow(rg_unf));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, registered dout = last word popped.
  logic [W-1:0] q[$];
  logic m_ovf = 1'b0, m_unf = 1'b0;
  logic [W-1:0] m_dreg = '0;

  initial begin
    bit took, put, eo, eu;
    logic [W-1:0] w;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_dreg = '0;
      end else if (flush) begin
        q.delete();
        m_ovf = m_ovf && !err_clr;
        m_unf = m_unf && !err_clr;
      end else begin
        took = pop && (q.size() > 0);
        put  = push && ((q.size() < D) || took);
        eo   = push && !put;
        eu   = pop && (q.size() == 0);
        if (took) begin w = q.pop_front(); m_dreg = w; end
        if (put) q.push_back(din);
        m_ovf = eo || (m_ovf && !err_clr);
        m_unf = eu || (m_unf && !err_clr);
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    int n;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        n = q.size();
        chk("sa_count", 32'(sa_count), 32'(n));
        chk("rg_count", 32'(rg_count), 32'(n));
        chk("sa_full", 32'(sa_full), 32'(n == D));
        chk("rg_full", 32'(rg_full), 32'(n == D));
        chk("sa_afull", 32'(sa_afull), 32'(n >= AF));
        chk("rg_afull", 32'(rg_afull), 32'(n >= AF));
        chk("sa_empty", 32'(sa_empty), 32'(n == 0));
        chk("rg_empty", 32'(rg_empty), 32'(n == 0));
        chk("sa_aempty", 32'(sa_aempty), 32'(n <= AE));
        chk("rg_aempty", 32'(rg_aempty), 32'(n <= AE));
        chk("sa_ovf", 32'(sa_ovf), 32'(m_ovf));
        chk("rg_ovf", 32'(rg_ovf), 32'(m_ovf));
        chk("sa_unf", 32'(sa_unf), 32'(m_unf));
        chk("rg_unf", 32'(rg_unf), 32'(m_unf));
        chk("rg_dout", 32'(rg_dout), 32'(m_dreg));
        if (n > 0) chk("sa_dout", 32'(sa_dout), 32'(q[0]));
      end
    end
  end

  task automatic step(input logic ps, input logic [W-1:0] d, input logic pp,
                      input logic fl = 1'b0, input logic ec = 1'b0);
    push = ps; din = d; pop = pp; flush = fl; err_clr = ec;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 32'(sa_count), 0);
    chk("rst_empty", 32'(sa_empty), 1);
    chk("rst_aempty", 32'(sa_aempty), 1);
    chk("rst_full", 32'(sa_full), 0);
    chk("rst_rg_dout", 32'(rg_dout), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1. fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, W'(i), 1'b0);
      chk("fill_count", 32'(sa_count), 32'(i));
      chk("fill_aempty", 32'(sa_aempty), (i <= 2) ? 1 : 0);
      chk("fill_afull", 32'(sa_afull), (i >= 6) ? 1 : 0);
      chk("fill_full", 32'(rg_full), (i == 8) ? 1 : 0);
      chk("fill_empty", 32'(rg_empty), 0);
    end

    // 2. overflow, drain in order, clear
    step(1'b1, 8'hFF, 1'b0);
    chk("ovf_set", 32'(sa_ovf), 1);
    chk("ovf_count", 32'(sa_count), 8);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_head", 32'(sa_dout), 32'(i));
      step(1'b0, '0, 1'b1);
      chk("drain_reg", 32'(rg_dout), 32'(i));
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(rg_ovf), 0);

    // 3. push+pop while full, wrap check
    for (int i = 1; i <= 8; i++) step(1'b1, W'(8'h20 + i), 1'b0);
    step(1'b1, 8'h55, 1'b1);
    chk("pp_full_count", 32'(sa_count), 8);
    chk("pp_full_full", 32'(sa_full), 1);
    chk("pp_full_reg", 32'(rg_dout), 32'h21);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1);
    chk("wrap_reg7", 32'(rg_dout), 32'h28);
    chk("wrap_head", 32'(sa_dout), 32'h55);
    step(1'b0, '0, 1'b1);
    chk("wrap_reg8", 32'(rg_dout), 32'h55);

    // error event beats err_clr in the same cycle
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("unf_beats_clr", 32'(sa_unf), 1);

    // 4. underflow, then push+pop while empty
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("unf_clr", 32'(sa_unf), 0);
    step(1'b0, '0, 1'b1);
    chk("unf_set", 32'(sa_unf), 1);
    chk("unf_count", 32'(sa_count), 0);
    step(1'b1, 8'hA5, 1'b1);
    chk("pe_count", 32'(sa_count), 1);
    chk("pe_sa_dout", 32'(sa_dout), 32'hA5);

    // 5. registered read port timing
    step(1'b0, '0, 1'b1);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("rg_first", 32'(rg_dout), 32'h11);
    step(1'b0, '0, 1'b1);
    chk("rg_second", 32'(rg_dout), 32'h22);
    step(1'b0, '0, 1'b0);
    chk("rg_hold", 32'(rg_dout), 32'h22);

    // 6. flush with push at count 5
    for (int i = 1; i <= 5; i++) step(1'b1, W'(8'h30 + i), 1'b0);
    chk("pre_flush_count", 32'(sa_count), 5);
    step(1'b1, 8'h99, 1'b0, 1'b1);
    chk("flush_count", 32'(sa_count), 0);
    chk("flush_empty", 32'(sa_empty), 1);
    chk("flush_ovf", 32'(sa_ovf), 0);
    chk("flush_unf_kept", 32'(rg_unf), 1);
    chk("flush_dout_hold", 32'(rg_dout), 32'h22);
    step(1'b1, 8'h77, 1'b0);
    chk("post_flush_head", 32'(sa_dout), 32'h77);

    // asynchronous reset mid-burst
    for (int i = 1; i <= 3; i++) step(1'b1, W'(8'h40 + i), 1'b0);
    step(1'b0, '0, 1'b1);
    push = 1'b1; din = 8'h50;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("arst_count", 32'(sa_count), 0);
    chk("arst_rg_count", 32'(rg_count), 0);
    chk("arst_empty", 32'(rg_empty), 1);
    chk("arst_aempty", 32'(sa_aempty), 1);
    chk("arst_full", 32'(sa_full), 0);
    chk("arst_afull", 32'(sa_afull), 0);
    chk("arst_unf", 32'(sa_unf), 0);
    chk("arst_rg_dout", 32'(rg_dout), 0);
    push = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 8'h66, 1'b0);
    chk("after_rst_head", 32'(sa_dout), 32'h66);
    step(1'b0, '0, 1'b1);
    chk("after_rst_reg", 32'(rg_dout), 32'h66);
    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
